// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared constants, state enum and error codes for the FIX checksum checker
package fix_pkg;

  localparam logic [7:0] SOH_DEFAULT = 8'h01;
  localparam logic [7:0] DIGIT0      = 8'h30;
  localparam logic [7:0] ONE         = 8'h31;
  localparam logic [7:0] EQ          = 8'h3D;
  localparam logic [7:0] START       = 8'h38;

  localparam int MAX_LEN_DEFAULT = 4096;

  typedef enum logic [3:0] {
    IDLE,
    BODY,
    SEEN_SOH,
    SEEN_1,
    SEEN_10,
    DIG0,
    DIG1,
    DIG2,
    TERM,
    REPORT
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_FORMAT   = 2'd2;
  localparam logic [1:0] ERR_LENGTH   = 2'd3;

endpackage

// File: rtl/fix_dec3_parse.sv
// rtl/fix_dec3_parse.sv - three-digit ASCII decimal accumulator with digit-valid flag
module fix_dec3_parse
  import fix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [9:0] val,
  output logic       digit_ok
);

  logic [7:0] digit;

  assign digit_ok = (data >= DIGIT0) && (data <= DIGIT0 + 8'd9);
  assign digit    = data - DIGIT0;

  // Three digits never exceed 999, so 10 bits hold the full value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (en && digit_ok) begin
      val <= val * 10'd10 + {2'b00, digit};
    end
  end

endmodule

// File: rtl/fix_checksum_check.sv
// rtl/fix_checksum_check.sv - receive-side FIX checksum verifier; FIX_CKSUM_STATS_EN adds pass/fail counters
module fix_checksum_check
  import fix_pkg::*;
#(
  parameter logic [7:0] SOH     = SOH_DEFAULT,
  parameter int         MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [1:0]  err_o,
  output logic [7:0]  calc_checksum_o,
  output logic [7:0]  rcv_checksum_o,
  output logic [15:0] pass_cnt_o,
  output logic [15:0] fail_cnt_o
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t        state;
  logic [7:0]    sum;
  logic [7:0]    snap;
  logic [LW-1:0] len;
  logic [7:0]    sum_add;
  logic [9:0]    val;
  logic          digit_ok;
  logic          in_digits;
  logic          dec_clr;
  logic          dec_en;
  logic          rep;
  logic [1:0]    rep_err;

  assign sum_add   = sum + data_i;
  assign busy_o    = (state != IDLE) && (state != REPORT);
  assign in_digits = (state == DIG0) || (state == DIG1) || (state == DIG2);

  // The accumulator must survive idle cycles while waiting for the terminator.
  assign dec_clr = !(in_digits || state == TERM);
  assign dec_en  = valid_i && !start_i && !rep && in_digits;

  fix_dec3_parse u_dec (
    .clk      (clk),
    .rst      (rst),
    .clr      (dec_clr),
    .en       (dec_en),
    .data     (data_i),
    .val      (val),
    .digit_ok (digit_ok)
  );

  always_comb begin
    rep     = 1'b0;
    rep_err = ERR_NONE;
    if (valid_i && !start_i && busy_o) begin
      if (len == LW'(MAX_LEN)) begin
        rep     = 1'b1;
        rep_err = ERR_LENGTH;
      end else if (in_digits) begin
        if (!digit_ok) begin
          rep     = 1'b1;
          rep_err = ERR_FORMAT;
        end
      end else if (state == TERM) begin
        rep = 1'b1;
        if (data_i != SOH || val > 10'd255) rep_err = ERR_FORMAT;
        else if (val[7:0] == sum)            rep_err = ERR_NONE;
        else                                 rep_err = ERR_MISMATCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      sum             <= '0;
      snap            <= '0;
      len             <= '0;
      done_o          <= 1'b0;
      pass_o          <= 1'b0;
      err_o           <= ERR_NONE;
      calc_checksum_o <= '0;
      rcv_checksum_o  <= '0;
    end else begin
      done_o <= 1'b0;
      if (state == REPORT) begin
        state <= IDLE;
      end else if (valid_i) begin
        if (start_i) begin
          // A start byte always begins a fresh message, silently abandoning any other.
          sum   <= data_i;
          len   <= LW'(1);
          state <= BODY;
        end else if (rep) begin
          state           <= REPORT;
          done_o          <= 1'b1;
          pass_o          <= (rep_err == ERR_NONE);
          err_o           <= rep_err;
          calc_checksum_o <= sum;
          rcv_checksum_o  <= val[7:0];
        end else if (state != IDLE) begin
          len <= len + LW'(1);
          case (state)
            BODY: begin
              sum <= sum_add;
              if (data_i == SOH) begin
                snap  <= sum_add;
                state <= SEEN_SOH;
              end
            end
            SEEN_SOH: begin
              sum <= sum_add;
              if (data_i == ONE)      state <= SEEN_1;
              else if (data_i == SOH) snap  <= sum_add;
              else                    state <= BODY;
            end
            SEEN_1: begin
              sum <= sum_add;
              if (data_i == DIGIT0) begin
                state <= SEEN_10;
              end else if (data_i == SOH) begin
                snap  <= sum_add;
                state <= SEEN_SOH;
              end else begin
                state <= BODY;
              end
            end
            SEEN_10: begin
              if (data_i == EQ) begin
                sum   <= snap;
                state <= DIG0;
              end else if (data_i == SOH) begin
                sum   <= sum_add;
                snap  <= sum_add;
                state <= SEEN_SOH;
              end else begin
                sum   <= sum_add;
                state <= BODY;
              end
            end
            DIG0:    state <= DIG1;
            DIG1:    state <= DIG2;
            DIG2:    state <= TERM;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

`ifdef FIX_CKSUM_STATS_EN
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (done_o) begin
      if (pass_o) begin
        if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
      end else begin
        if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
      end
    end
  end

  assign pass_cnt_o = pass_cnt;
  assign fail_cnt_o = fail_cnt;
`else
  assign pass_cnt_o = '0;
  assign fail_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fix_checksum_check.sv
// tb/tb_fix_checksum_check.sv - directed self-checking bench for fix_checksum_check
module tb_fix_checksum_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        valid_i = 1'b0;
  logic        start_i = 1'b0;

  logic        busy_o, done_o, pass_o;
  logic [1:0]  err_o;
  logic [7:0]  calc_checksum_o, rcv_checksum_o;
  logic [15:0] pass_cnt_o, fail_cnt_o;

  logic        dl_busy, dl_done, dl_pass;
  logic [1:0]  dl_err;
  logic [7:0]  dl_calc, dl_rcv;
  logic [15:0] dl_pcnt, dl_fcnt;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int d0 = 0;
  int exp_pcnt = 0;
  int exp_fcnt = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (done_o) done_cnt <= done_cnt + 1;

  fix_checksum_check dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_o(err_o),
    .calc_checksum_o(calc_checksum_o), .rcv_checksum_o(rcv_checksum_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o)
  );

  fix_checksum_check #(.MAX_LEN(16)) dut_len (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .start_i(start_i),
    .busy_o(dl_busy), .done_o(dl_done), .pass_o(dl_pass), .err_o(dl_err),
    .calc_checksum_o(dl_calc), .rcv_checksum_o(dl_rcv),
    .pass_cnt_o(dl_pcnt), .fail_cnt_o(dl_fcnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send(input logic [7:0] b, input logic st);
    data_i = b; valid_i = 1'b1; start_i = st;
    @(posedge clk); #1;
    valid_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic add_s(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic msg_std(input string digits);
    q.delete();
    add_s("8=A"); q.push_back(8'h01); add_s("10="); add_s(digits); q.push_back(8'h01);
  endtask

  task automatic send_q();
    d0 = done_cnt;
    for (int i = 0; i < q.size(); i++) send(q[i], i == 0);
  endtask

  // Called #1 after the edge that sampled the final byte: done_o must already be high.
  task automatic expect_report(input string tag, input logic ep, input logic [1:0] ee,
                               input int ec, input int er);
    check({tag, "_done"}, done_o, 1);
    check({tag, "_pass"}, pass_o, ep);
    check({tag, "_err"}, err_o, ee);
    check({tag, "_calc"}, calc_checksum_o, ec);
    if (er >= 0) check({tag, "_rcv"}, rcv_checksum_o, er);
    if (ep) exp_pcnt++; else exp_fcnt++;
    @(posedge clk); #1;
    check({tag, "_pulse"}, done_o, 0);
    check({tag, "_count"}, done_cnt, d0 + 1);
  endtask

  initial begin
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_calc", calc_checksum_o, 0);
    check("rst_err", err_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    msg_std("183");
    d0 = done_cnt;
    for (int i = 0; i < q.size(); i++) begin
      send(q[i], i == 0);
      if (i == 2) check("busy_mid", busy_o, 1);
      if (i == q.size() - 2) check("no_early_done", done_o, 0);
    end
    expect_report("pass183", 1, 0, 183, 183);

    q.delete(); add_s("8=A");
    send_q();
    rst = 1'b0; #2;
    check("mrst_busy", busy_o, 0);
    check("mrst_calc", calc_checksum_o, 0);
    check("mrst_rcv", rcv_checksum_o, 0);
    check("mrst_pass", pass_o, 0);
    exp_pcnt = 0; exp_fcnt = 0;
    @(posedge clk); #3 rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("mrst_nodone", done_cnt, d0);

    msg_std("184"); send_q();
    expect_report("mismatch", 0, 1, 183, 184);

    q.delete(); add_s("8="); q.push_back(8'hFF); q.push_back(8'h01); add_s("10=117"); q.push_back(8'h01);
    send_q();
    expect_report("wrap117", 1, 0, 117, 117);

    q.delete(); add_s("8="); q.push_back(8'hFF); q.push_back(8'h01); add_s("10=300"); q.push_back(8'h01);
    send_q();
    expect_report("wrap300", 0, 2, 117, 44);

    q.delete(); add_s("8=A"); q.push_back(8'h01); add_s("10=1A");
    send_q();
    expect_report("fmt_digit", 0, 2, 183, -1);
    send(8'h33, 1'b0); send(8'h01, 1'b0); @(posedge clk); #1;
    check("fmt_tail_dropped", done_cnt, d0 + 1);

    q.delete(); add_s("8=A"); q.push_back(8'h01); add_s("10=183X");
    send_q();
    expect_report("fmt_term", 0, 2, 183, 183);

    q.delete(); add_s("8=A"); q.push_back(8'h01); add_s("1X"); q.push_back(8'h01);
    add_s("10X"); q.push_back(8'h01); add_s("10=251"); q.push_back(8'h01);
    send_q();
    expect_report("partial", 1, 0, 251, 251);

    q.delete(); add_s("8=A"); q.push_back(8'h01); add_s("10=1");
    send_q();
    check("abort_busy", busy_o, 1);
    msg_std("183");
    for (int i = 0; i < q.size(); i++) send(q[i], i == 0);
    expect_report("abort_restart", 1, 0, 183, 183);

    q.delete(); add_s("8=AAAAAAAAAAA"); q.push_back(8'h01); add_s("10=065"); q.push_back(8'h01);
    d0 = done_cnt;
    for (int i = 0; i < q.size(); i++) begin
      send(q[i], i == 0);
      if (i == 15) check("len_b16_done", dl_done, 0);
      if (i == 16) begin
        check("len_b17_done", dl_done, 1);
        check("len_b17_err", dl_err, 3);
        check("len_b17_pass", dl_pass, 0);
      end
    end
    expect_report("len_big_ok", 1, 0, 65, 65);

`ifdef FIX_CKSUM_STATS_EN
    check("stats_pass", pass_cnt_o, exp_pcnt);
    check("stats_fail", fail_cnt_o, exp_fcnt);
`else
    check("stats_pass_tied", pass_cnt_o, 0);
    check("stats_fail_tied", fail_cnt_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
